// File: rtl/fft_pkg.sv
// fft_pkg: shared lane count, frame geometry and sample types for the streaming FFT
package fft_pkg;
    localparam int DATA_W = 9;
    localparam int NUM_LANES = 16;
    localparam int FRAME_BEATS = 32;
    localparam int HALF_BEATS = 16;
    typedef logic signed [DATA_W-1:0] in_sample_t;
    typedef logic signed [DATA_W:0] bfly_sample_t;
endpackage

// File: rtl/bfly00_stage_if.sv
// bfly00_stage_if: input beat bus and butterfly result bus of the first FFT stage
interface bfly00_stage_if #(parameter int WIDTH = 9);
    import fft_pkg::*;
    logic din_valid;
    logic din_sof;
    logic signed [WIDTH-1:0] din_re [NUM_LANES];
    logic signed [WIDTH-1:0] din_im [NUM_LANES];
    logic bfly00_valid;
    logic sync_err;
    logic signed [WIDTH:0] o_00bfly_sum_re [NUM_LANES];
    logic signed [WIDTH:0] o_00bfly_sum_im [NUM_LANES];
    logic signed [WIDTH:0] o_00bfly_diff_re [NUM_LANES];
    logic signed [WIDTH:0] o_00bfly_diff_im [NUM_LANES];
    modport master (
        output din_valid, din_sof, din_re, din_im,
        input bfly00_valid, sync_err, o_00bfly_sum_re, o_00bfly_sum_im,
        o_00bfly_diff_re, o_00bfly_diff_im
    );
    modport slave (
        input din_valid, din_sof, din_re, din_im,
        output bfly00_valid, sync_err, o_00bfly_sum_re, o_00bfly_sum_im,
        o_00bfly_diff_re, o_00bfly_diff_im
    );
endinterface

// File: rtl/bfly2_lane.sv
// bfly2_lane: full-precision radix-2 sum/difference of one complex pair
module bfly2_lane
    import fft_pkg::*;
(
    input  in_sample_t   a_re,
    input  in_sample_t   a_im,
    input  in_sample_t   b_re,
    input  in_sample_t   b_im,
    output bfly_sample_t sum_re,
    output bfly_sample_t sum_im,
    output bfly_sample_t diff_re,
    output bfly_sample_t diff_im
);
    // widen before the add so the carry bit is never lost
    assign sum_re  = bfly_sample_t'(a_re) + bfly_sample_t'(b_re);
    assign sum_im  = bfly_sample_t'(a_im) + bfly_sample_t'(b_im);
    assign diff_re = bfly_sample_t'(a_re) - bfly_sample_t'(b_re);
    assign diff_im = bfly_sample_t'(a_im) - bfly_sample_t'(b_im);
endmodule

// File: rtl/bfly00_stage.sv
// bfly00_stage: first DIF butterfly stage; buffers half a frame and pairs x[n] with x[n+256]
module bfly00_stage
    import fft_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int CLK_CNT = 5
) (
    input logic clk,
    input logic rst,
    bfly00_stage_if.slave bus
);
    logic [CLK_CNT-1:0] beat_cnt;
    logic [CLK_CNT-2:0] idx;
    logic [CLK_CNT-2:0] wr_idx;
    logic pair;
    logic mid_sof;
    logic signed [WIDTH-1:0] buf_re [HALF_BEATS][NUM_LANES];
    logic signed [WIDTH-1:0] buf_im [HALF_BEATS][NUM_LANES];
    bfly_sample_t sum_re [NUM_LANES];
    bfly_sample_t sum_im [NUM_LANES];
    bfly_sample_t diff_re [NUM_LANES];
    bfly_sample_t diff_im [NUM_LANES];

    assign idx = beat_cnt[CLK_CNT-2:0];
    assign pair = beat_cnt[CLK_CNT-1];
    assign mid_sof = bus.din_sof && beat_cnt != '0;
    // a resync beat restarts the frame, so it lands in slot 0
    assign wr_idx = mid_sof ? '0 : idx;

    for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
        bfly2_lane u_lane (
            .a_re(buf_re[idx][j]),
            .a_im(buf_im[idx][j]),
            .b_re(bus.din_re[j]),
            .b_im(bus.din_im[j]),
            .sum_re(sum_re[j]),
            .sum_im(sum_im[j]),
            .diff_re(diff_re[j]),
            .diff_im(diff_im[j])
        );
    end

    always_ff @(posedge clk)
        if (bus.din_valid && (!pair || mid_sof)) begin
            buf_re[wr_idx] <= bus.din_re;
            buf_im[wr_idx] <= bus.din_im;
        end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            bus.bfly00_valid <= 1'b0;
            bus.sync_err <= 1'b0;
            bus.o_00bfly_sum_re <= '{default: '0};
            bus.o_00bfly_sum_im <= '{default: '0};
            bus.o_00bfly_diff_re <= '{default: '0};
            bus.o_00bfly_diff_im <= '{default: '0};
        end else begin
            bus.sync_err <= bus.din_valid && mid_sof;
            bus.bfly00_valid <= bus.din_valid && pair && !mid_sof;
            if (bus.din_valid)
                beat_cnt <= mid_sof ? CLK_CNT'(1) : beat_cnt + CLK_CNT'(1);
            if (bus.din_valid && pair && !mid_sof) begin
                bus.o_00bfly_sum_re <= sum_re;
                bus.o_00bfly_sum_im <= sum_im;
                bus.o_00bfly_diff_re <= diff_re;
                bus.o_00bfly_diff_im <= diff_im;
            end
        end
    end
endmodule

// File: doc/bfly00_stage.md
# bfly00_stage

First radix-2 DIF butterfly stage of the 512-point, 16-lane streaming FFT. Accepts a frame as 32 beats of 16 complex samples, buffers the first half-frame, then pairs each second-half beat with its stored counterpart (x[n], x[n+256]) and emits registered sum/difference vectors. Its outputs and `bfly00_valid` drive the stage-0 twiddle multiplier (`twd00_valid` and the `i_00bfly_*` inputs) directly.

## Interface
- `WIDTH`, 9: output sample is `[WIDTH:0]` (<4.6>); input sample is `[WIDTH-1:0]` (<3.6>)
- `CLK_CNT`, 5: beat-counter width; 2**CLK_CNT = 32 beats per frame
- `clk`  in  1  clock; all logic rising-edge
- `rst`  in  1  reset; synchronous, active-high
- `din_valid`  in  1  input beat qualifier
- `din_sof`  in  1  start of frame; sampled only with `din_valid`
- `din_re[0:15]`, `din_im[0:15]`  in  signed `[WIDTH-1:0]` each  lane samples; lane j of beat b is sample 16b+j
- `bfly00_valid`  out  1  output beat qualifier
- `o_00bfly_sum_re[0:15]`, `o_00bfly_sum_im[0:15]`  out  signed `[WIDTH:0]`  x[n]+x[n+256]
- `o_00bfly_diff_re[0:15]`, `o_00bfly_diff_im[0:15]`  out  signed `[WIDTH:0]`  x[n]-x[n+256]
- `sync_err`  out  1  one-cycle pulse: `din_sof` seen mid-frame

## Operation
- Beat counter `beat_cnt` (`CLK_CNT` bits) increments on each `din_valid` beat; wraps 31→0.
- States: FILL (`beat_cnt` 0–15), PAIR (`beat_cnt` 16–31). The state is `beat_cnt[4]`; no separate state register.
- FILL: the beat is written to `half_buf[beat_cnt[3:0]]` (16 entries × 16 lanes × re/im). No output.
- PAIR: read `half_buf[beat_cnt[3:0]]` as a, current beat as b. Per lane: sum = a+b, diff = a−b, both sign-extended to `WIDTH+1` bits before the add. Full precision: no rounding, no saturation.
- The output registers and `bfly00_valid` load on a PAIR beat. With no PAIR beat, `bfly00_valid`=0 and the data outputs hold their last value.
- `din_sof`:
  - With `din_valid` at `beat_cnt`=0: normal.
  - With `din_valid` at `beat_cnt`≠0: the partial frame is discarded. The beat is taken as beat 0 (written to `half_buf[0]`), `beat_cnt`←1, `sync_err`=1 next cycle. No output for this beat.
- Gaps: `din_valid` low freezes all state. Gaps appear 1:1 as gaps in `bfly00_valid`.
- Back-to-back frames: beat 0 of frame k+1 may directly follow beat 31 of frame k.

## Timing
- Latency: PAIR input beat at cycle t → `bfly00_valid`/data valid at t+1.
- Per gap-free frame: 16 idle cycles of `bfly00_valid`, then 16 consecutive high cycles. Downstream twiddle counter idx = cnt/8 therefore selects 1 for output beats 0–7 and −j for beats 8–15.
- Reset (any cycle, including mid-frame):
  - `beat_cnt`←0
  - `bfly00_valid`←0
  - `sync_err`←0
  - all data outputs ←0
  - `half_buf` contents are don't-care; every entry is rewritten before it is read.
- `rst` has priority over `din_valid`/`din_sof` in the same cycle.
- Arithmetic extremes: a=b=−256 gives sum −512, diff 0. a=255, b=−256 gives diff 511. All fit in 10 bits at WIDTH=9.

## Structure
- Shared package `fft_pkg`:
  - `NUM_LANES`=16
  - `FRAME_BEATS`=32, `HALF_BEATS`=16
  - typedefs `in_sample_t` (signed `[WIDTH-1:0]`) and `bfly_sample_t` (signed `[WIDTH:0]`)
- Sub-module `bfly2_lane`: combinational sign-extend plus add/sub for one complex pair, instantiated 16 times via generate.
- Top holds the counter, `half_buf`, sof/error logic and the output registers.

## Test plan
- Ramp frame, lane j of beat b re=(16b+j) mod 256 − 128, im=0, gap-free:
  - `bfly00_valid` high cycles 17–32 after the first beat.
  - Output beat k lane j: sum_re = 2·((16k+j) mod 256 − 128); diff_re = 0 when (16k+j)<128 … per formula, diff = a−b computed exactly. Check all 256 lanes against the model.
- Extremes: first half all −256, second half all −256, im first half 255 / second half −256:
  - sum_re=−512, diff_re=0, sum_im=−1, diff_im=511.
- Random gaps (`din_valid` 50%) over 3 back-to-back frames:
  - exactly 48 `bfly00_valid` pulses; data matches the gap-free run beat-for-beat.
- `din_sof` at beat 20 of frame 1:
  - `sync_err` pulses once, next cycle.
  - No output for the discarded remainder.
  - The new frame produces 16 correct outputs after its beat 15.
- `rst` asserted at beat 24 for 1 cycle:
  - all outputs 0 the following cycle.
  - The next frame, starting with `din_sof`, outputs correctly with no stale pairing.
- Chain into the stage-0 twiddle multiplier:
  - output beats 8–15 show diff_re = diff_im_in and diff_im = −diff_re_in.
